// File: rtl/mdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM state
// encoding, operation select codes and the most-negative-value helper.
package mdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // Widest operand the MIN helper can describe.
    localparam int MAX_W = 64;

    // Two's-complement most negative value for a given width, right-aligned
    // in a MAX_W-bit word; callers keep the low 'width' bits.
    function automatic logic [MAX_W-1:0] min_value(input int unsigned width);
        min_value = {{(MAX_W-1){1'b0}}, 1'b1} << (width - 1);
    endfunction

endpackage

// File: rtl/mdiv_step.sv
// Single radix-2 iteration of the multiply/divide datapath.
// acc holds {hi, lo}: for multiply hi is the partial product and lo the
// remaining multiplier bits; for divide hi is the partial remainder and lo
// the dividend bits being shifted out while quotient bits shift in.
module mdiv_step
    import mdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               op_sel,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] hi_s;
    logic [WIDTH-1:0] lo_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic             fits_s;

    // One add-or-hold (multiply) or trial-subtract/restore (divide) step.
    always_comb begin
        hi_s      = acc[2*WIDTH-1:WIDTH];
        lo_s      = acc[WIDTH-1:0];
        sum_s     = {1'b0, hi_s} + (lo_s[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        shifted_s = {hi_s, lo_s[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, operand};
        fits_s    = (shifted_s >= {1'b0, operand});
        if (op_sel == OP_MULT) begin
            // Carry lands in the top bit, multiplier shifts out the bottom.
            acc_next = {sum_s, lo_s[WIDTH-1:1]};
        end else begin
            // Remainder always stays below the divisor, so WIDTH bits suffice.
            acc_next = {WIDTH'(fits_s ? trial_s : shifted_s), lo_s[WIDTH-2:0], fits_s};
        end
    end

endmodule

// File: rtl/mdiv_iter_unit.sv
// Iterative signed multiply/divide unit for the execute stage.
// Operands are latched as magnitudes at issue, WIDTH radix-2 steps run in
// MULT or DIV, then sign fix-up and exception detection are registered into
// the outputs on entry to DONE, where result_valid pulses for one cycle.
// Optional build macro MDIV_EARLY_OUT_EN: operations with a zero operand
// bypass the iteration and complete one edge after issue without busy.
module mdiv_iter_unit
    import mdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic [TAG_W-1:0] tag_out
);

    localparam int                 CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [MAX_W-1:0]   MIN_WIDE = min_value(WIDTH);
    localparam logic [WIDTH-1:0]   MIN_VAL  = MIN_WIDE[WIDTH-1:0];
    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   ZERO_C   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   LAST_C   = CNT_W'(WIDTH);

    state_t             state_r;
    logic               op_r;
    logic               sign_r;
    logic [WIDTH-1:0]   operand_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [TAG_W-1:0]   tag_r;
    logic               busy_r;
    logic               valid_r;
    logic [WIDTH-1:0]   result_r;
    logic               exc_r;
    logic [TAG_W-1:0]   tag_out_r;

    logic               issue_s;
    logic               early_s;
    logic [WIDTH-1:0]   abs_a_s;
    logic [WIDTH-1:0]   abs_b_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [2*WIDTH-1:0] prod_signed_s;
    logic [WIDTH-1:0]   quot_signed_s;
    logic [WIDTH-1:0]   fin_result_s;
    logic               fin_exc_s;

    mdiv_step #(.WIDTH(WIDTH)) u_step (
        .op_sel   (op_r),
        .acc      (acc_r),
        .operand  (operand_r),
        .acc_next (acc_next_s)
    );

    // Issue decode and operand magnitudes. Read as unsigned, the magnitude
    // of MIN is exactly 2^(WIDTH-1), so WIDTH bits carry it without loss.
    always_comb begin
        issue_s = (start_mult | start_div) & ~flush;
        abs_a_s = op_a[WIDTH-1] ? (~op_a + ONE_W) : op_a;
        abs_b_s = op_b[WIDTH-1] ? (~op_b + ONE_W) : op_b;
`ifdef MDIV_EARLY_OUT_EN
        early_s = (op_a == ZERO_W) || (op_b == ZERO_W);
`else
        early_s = 1'b0;
`endif
    end

    // Sign fix-up and exception detection on the finished magnitude.
    always_comb begin
        prod_signed_s = sign_r ? (~acc_r + ONE_2W) : acc_r;
        quot_signed_s = sign_r ? (~acc_r[WIDTH-1:0] + ONE_W) : acc_r[WIDTH-1:0];
        if (op_r == OP_MULT) begin
            fin_result_s = prod_signed_s[WIDTH-1:0];
            // Fits in signed WIDTH only if the upper WIDTH+1 bits agree.
            fin_exc_s    = ~((&prod_signed_s[2*WIDTH-1:WIDTH-1]) |
                             ~(|prod_signed_s[2*WIDTH-1:WIDTH-1]));
        end else if (operand_r == ZERO_W) begin
            fin_result_s = ZERO_W;
            fin_exc_s    = 1'b1;
        end else begin
            // Only MIN / -1 yields a positive quotient of 2^(WIDTH-1).
            fin_result_s = quot_signed_s;
            fin_exc_s    = ~sign_r & (acc_r[WIDTH-1:0] == MIN_VAL);
        end
    end

    // Control FSM, iteration counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            op_r      <= OP_MULT;
            sign_r    <= 1'b0;
            operand_r <= ZERO_W;
            acc_r     <= ZERO_2W;
            cnt_r     <= ZERO_C;
            tag_r     <= {TAG_W{1'b0}};
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            result_r  <= ZERO_W;
            exc_r     <= 1'b0;
            tag_out_r <= {TAG_W{1'b0}};
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (issue_s) begin
                        state_r <= start_mult ? MULT : DIV;
                        op_r    <= start_mult ? OP_MULT : OP_DIV;
                        sign_r  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        tag_r   <= tag_in;
                        // Early-out parks the counter at its end so the next
                        // edge completes without stepping.
                        cnt_r   <= early_s ? LAST_C : ZERO_C;
                        busy_r  <= ~early_s;
                        if (start_mult) begin
                            operand_r <= abs_a_s;
                            acc_r     <= early_s ? ZERO_2W : {ZERO_W, abs_b_s};
                        end else begin
                            operand_r <= abs_b_s;
                            acc_r     <= {ZERO_W, abs_a_s};
                        end
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                MULT, DIV: begin
                    if (flush) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (cnt_r == LAST_C) begin
                        state_r   <= DONE;
                        busy_r    <= 1'b0;
                        valid_r   <= 1'b1;
                        result_r  <= fin_result_s;
                        exc_r     <= fin_exc_s;
                        tag_out_r <= tag_r;
                    end else begin
                        acc_r <= acc_next_s;
                        cnt_r <= cnt_r + ONE_C;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_r;
    assign result_valid = valid_r;
    assign result       = result_r;
    assign exception    = exc_r;
    assign tag_out      = tag_out_r;

endmodule

// File: tb/tb_mdiv_iter_unit.sv
// Self-checking bench for mdiv_iter_unit (WIDTH=32, TAG_W=5): directed
// scenarios plus randomized operations checked against a 64-bit integer
// arithmetic reference model.
`timescale 1ns/1ps
module tb_mdiv_iter_unit;

    localparam int          W     = 32;
    localparam int          TW    = 5;
    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic          clock;
    logic          reset;
    logic          start_mult;
    logic          start_div;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [TW-1:0] tag_in;
    logic          flush;
    logic          busy;
    logic          result_valid;
    logic [W-1:0]  result;
    logic          exception;
    logic [TW-1:0] tag_out;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [W-1:0]  last_res;

    mdiv_iter_unit #(.WIDTH(W), .TAG_W(TW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start_mult   (start_mult),
        .start_div    (start_div),
        .op_a         (op_a),
        .op_b         (op_b),
        .tag_in       (tag_in),
        .flush        (flush),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .exception    (exception),
        .tag_out      (tag_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: signed arithmetic in 64 bits.
    function automatic void model(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint sa;
        longint sb;
        longint p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mult) begin
            p = sa * sb;
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (sb == 64'sd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (sa == -64'sd2147483648 && sb == -64'sd1) begin
            r = MIN32;
            e = 1'b1;
        end else begin
            p = sa / sb;
            r = p[31:0];
            e = 1'b0;
        end
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MDIV_EARLY_OUT_EN
        if (a == 32'd0 || b == 32'd0) return 1;
`endif
        return W + 1;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = MIN32;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'(int'($urandom_range(0, 40)) - 20);
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // Issue one op, wait for its pulse, and check latency, busy time and outputs.
    // Returns during the DONE cycle so a following call issues back-to-back.
    task automatic run_op(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                          input logic [TW-1:0] tg);
        int          lat;
        int          busy_cnt;
        int          el;
        logic [31:0] er;
        logic        ee;
        @(negedge clock);
        start_mult = is_mult;
        start_div  = ~is_mult;
        op_a       = a;
        op_b       = b;
        tag_in     = tg;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        busy_cnt   = busy ? 1 : 0;
        lat        = 0;
        for (int k = 1; k <= 100 && lat == 0; k++) begin
            @(posedge clock);
            #1;
            if (result_valid) lat = k;
            else if (busy) busy_cnt++;
        end
        model(is_mult, a, b, er, ee);
        el = exp_lat(a, b);
        check_val("latency", 64'(lat), 64'(el));
        check_val("busy_cycles", 64'(busy_cnt), 64'((el == 1) ? 0 : el));
        check_val("busy_at_valid", {63'd0, busy}, 64'd0);
        check_val("result", {32'd0, result}, {32'd0, er});
        check_val("exception", {63'd0, exception}, {63'd0, ee});
        check_val("tag_out", {59'd0, tag_out}, {59'd0, tg});
        last_res = er;
    endtask

    task automatic idle_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int seen;
        reset      = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        flush      = 1'b0;
        op_a       = 32'd0;
        op_b       = 32'd0;
        tag_in     = 5'd0;
        last_res   = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_valid", {63'd0, result_valid}, 64'd0);
        check_val("rst_result", {32'd0, result}, 64'd0);
        check_val("rst_exc", {63'd0, exception}, 64'd0);
        check_val("rst_tag", {59'd0, tag_out}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        idle_cycle();

        // 7 x -6
        run_op(1'b1, 32'd7, 32'hFFFF_FFFA, 5'd3);
        idle_cycle();
        check_val("pulse_one_cycle", {63'd0, result_valid}, 64'd0);
        check_val("result_hold", {32'd0, result}, {32'd0, last_res});

        // overflowing multiply, then divide issued from DONE with no gap
        run_op(1'b1, 32'h0001_0000, 32'h0001_0000, 5'd4);
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 5'd5);

        // divide by zero, MIN / -1
        run_op(1'b0, 32'd5, 32'd0, 5'd6);
        run_op(1'b0, MIN32, 32'hFFFF_FFFF, 5'd7);
        idle_cycle();

        // flush mid-multiply at E+10
        @(negedge clock);
        start_mult = 1'b1;
        op_a       = 32'd3;
        op_b       = 32'd4;
        tag_in     = 5'd1;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        check_val("busy_before_flush", {63'd0, busy}, 64'd1);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check_val("flush_busy", {63'd0, busy}, 64'd0);
        seen = 0;
        repeat (40) begin
            idle_cycle();
            if (result_valid) seen = 1;
        end
        check_val("flush_no_valid", 64'(seen), 64'd0);
        check_val("flush_hold", {32'd0, result}, {32'd0, last_res});
        run_op(1'b0, 32'd100, 32'd7, 5'd9);

        // flush in DONE together with a new start: no new operation
        run_op(1'b1, 32'd5, 32'd6, 5'd2);
        @(negedge clock);
        flush     = 1'b1;
        start_div = 1'b1;
        op_a      = 32'd100;
        op_b      = 32'd7;
        @(posedge clock);
        #1;
        flush     = 1'b0;
        start_div = 1'b0;
        check_val("done_flush_busy", {63'd0, busy}, 64'd0);
        seen = 0;
        repeat (40) begin
            idle_cycle();
            if (result_valid || busy) seen = 1;
        end
        check_val("done_flush_no_op", 64'(seen), 64'd0);

        // asynchronous reset mid-divide with a start held
        @(negedge clock);
        start_div = 1'b1;
        op_a      = 32'd1000;
        op_b      = 32'd3;
        tag_in    = 5'd11;
        @(posedge clock);
        #1;
        start_div = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        start_mult = 1'b1;
        op_a       = 32'd9;
        op_b       = 32'd9;
        reset      = 1'b0;
        #1;
        check_val("arst_busy", {63'd0, busy}, 64'd0);
        check_val("arst_result", {32'd0, result}, 64'd0);
        check_val("arst_exc", {63'd0, exception}, 64'd0);
        check_val("arst_tag", {59'd0, tag_out}, 64'd0);
        repeat (2) idle_cycle();
        check_val("arst_start_ignored", {63'd0, busy}, 64'd0);
        @(negedge clock);
        start_mult = 1'b0;
        reset      = 1'b1;
        last_res   = 32'd0;
        repeat (3) idle_cycle();
        check_val("post_rst_idle", {62'd0, busy, result_valid}, 64'd0);
        run_op(1'b1, 32'hFFFF_FFFD, 32'd11, 5'd12);

        // zero-operand operations (latency depends on early-out build)
        run_op(1'b1, 32'd0, 32'd12345, 5'd13);
        run_op(1'b0, 32'd0, 32'd17, 5'd14);
        run_op(1'b1, 32'd42, 32'd0, 5'd15);

        // randomized operations with random gaps
        for (int i = 0; i < 40; i++) begin
            int gap;
            run_op(1'($urandom_range(0, 1)), pick(), pick(), 5'($urandom_range(0, 31)));
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                idle_cycle();
                check_val("rand_gap_no_valid", {63'd0, result_valid}, 64'd0);
                check_val("rand_gap_hold", {32'd0, result}, {32'd0, last_res});
                if (gap > 1) idle_cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
